// File: rtl/dac_stream_pkg.sv
// Shared types and defaults for the DAC sample streaming path.
// Imported by the pacer and by any later stream stages.
package dac_stream_pkg;

  localparam int DATA_W = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } pacer_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush and occupancy count.
// Reusable by any stream stage: the head word is always visible on pop_data.
module sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                     mclk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers are PTR_W wide, so increments wrap modulo DEPTH for free.
  always_ff @(posedge mclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; contents are only read behind a non-zero
  // count, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge mclk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dac_sample_pacer.sv
// Buffers upstream samples and releases one per programmable period to the
// DAC driver, flagging underrun (nothing to send) and late (driver stalled).
module dac_sample_pacer
  import dac_stream_pkg::*;
#(
  parameter int DATA_W = dac_stream_pkg::DATA_W,
  parameter int DEPTH  = 16,
  parameter int DIV_W  = 16
) (
  input  logic                     mclk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     flush,
  input  logic [DIV_W-1:0]         rate_div,
  input  logic                     s_axis_valid,
  output logic                     s_axis_ready,
  input  logic [DATA_W-1:0]        s_axis_data,
  output logic                     m_axis_valid,
  input  logic                     m_axis_ready,
  output logic [DATA_W-1:0]        m_axis_data,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     underrun,
  output logic                     late
);

  pacer_state_t      state;
  logic [DIV_W-1:0]  tcnt;
  logic [DIV_W-1:0]  reload;
  logic              tick;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .mclk      (mclk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (s_axis_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fill_level)
  );

  // Ready comes from the registered count only, so a same-cycle pop never
  // opens a slot early.
  assign s_axis_ready = !fifo_full && !rst;
  assign push         = s_axis_valid && s_axis_ready;
  assign tick         = enable && (tcnt == '0);
  assign pop          = (state == IDLE) && tick && !fifo_empty;

  always_comb begin
    // NOTE: default first so no path leaves reload unassigned (no latch).
    reload = '0;
    if (rate_div != '0) reload = rate_div - DIV_W'(1);
  end

  // rate_div is only sampled at reload, so a change lands on the next period.
  always_ff @(posedge mclk) begin
    if (rst || !enable) tcnt <= '0;
    else if (tick)      tcnt <= reload;
    else                tcnt <= tcnt - DIV_W'(1);
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state        <= IDLE;
      m_axis_valid <= 1'b0;
      m_axis_data  <= '0;
      underrun     <= 1'b0;
      late         <= 1'b0;
    end else begin
      underrun <= 1'b0;
      late     <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            if (!fifo_empty) begin
              m_axis_data  <= fifo_head;
              m_axis_valid <= 1'b1;
              state        <= PRESENT;
            end else begin
              underrun <= 1'b1;
            end
          end
        end
        PRESENT: begin
          // The tick is dropped while a word is pending; valid is only
          // released by the handshake, never by enable or flush.
          if (tick) late <= 1'b1;
          if (m_axis_ready) begin
            m_axis_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          m_axis_valid <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_sample_pacer.sv
// Directed bench for dac_sample_pacer: reset, pacing, underrun, full FIFO,
// late, rate_div=0 with flush, and reset in the middle of a presentation.
module tb_dac_sample_pacer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int DIV_W  = 16;

  logic                   mclk = 1'b0;
  logic                   rst;
  logic                   enable;
  logic                   flush;
  logic [DIV_W-1:0]       rate_div;
  logic                   s_axis_valid;
  logic                   s_axis_ready;
  logic [DATA_W-1:0]      s_axis_data;
  logic                   m_axis_valid;
  logic                   m_axis_ready;
  logic [DATA_W-1:0]      m_axis_data;
  logic [$clog2(DEPTH):0] fill_level;
  logic                   underrun;
  logic                   late;

  int total = 0;
  int bad   = 0;

  logic [15:0] pace_words [4] = '{16'hCAFE, 16'hBEEF, 16'hFACE, 16'hC0DE};

  dac_sample_pacer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .DIV_W  (DIV_W)
  ) dut (
    .mclk         (mclk),
    .rst          (rst),
    .enable       (enable),
    .flush        (flush),
    .rate_div     (rate_div),
    .s_axis_valid (s_axis_valid),
    .s_axis_ready (s_axis_ready),
    .s_axis_data  (s_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_ready (m_axis_ready),
    .m_axis_data  (m_axis_data),
    .fill_level   (fill_level),
    .underrun     (underrun),
    .late         (late)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] d);
    s_axis_valid = 1'b1;
    s_axis_data  = d;
    step();
    s_axis_valid = 1'b0;
  endtask

  initial begin
    int np;
    rst          = 1'b1;
    enable       = 1'b0;
    flush        = 1'b0;
    rate_div     = '0;
    s_axis_valid = 1'b0;
    s_axis_data  = '0;
    m_axis_ready = 1'b0;

    // ---- power-on reset ----
    repeat (3) step();
    check("rst_ready",  32'(s_axis_ready), 0);
    check("rst_valid",  32'(m_axis_valid), 0);
    check("rst_data",   32'(m_axis_data), 0);
    check("rst_fill",   32'(fill_level), 0);
    rst = 1'b0;
    #1;
    check("rst_ready_after", 32'(s_axis_ready), 1);

    // ---- pacing, rate_div=5 ----
    for (int i = 0; i < 4; i++) push_word(pace_words[i]);
    check("pace_fill4", 32'(fill_level), 4);
    rate_div     = 16'd5;
    m_axis_ready = 1'b1;
    enable       = 1'b1;
    np           = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("pace_valid_k%0d", k), 32'(m_axis_valid), 32'((k % 5) == 1 && k <= 16));
      check($sformatf("pace_fill_k%0d", k), 32'(fill_level), 32'(4 - ((k + 4) / 5)));
      check("pace_underrun", 32'(underrun), 0);
      if ((k % 5) == 1 && k <= 16) begin
        check($sformatf("pace_data_%0d", np), 32'(m_axis_data), 32'(pace_words[np]));
        np++;
      end
    end
    enable = 1'b0;

    // ---- underrun, rate_div=4; a word written in a tick cycle still underruns ----
    rate_div = 16'd4;
    enable   = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      check($sformatf("und_pulse_k%0d", k), 32'(underrun), 32'((k % 4) == 1 && k <= 9));
      check($sformatf("und_valid_k%0d", k), 32'(m_axis_valid), 32'(k == 13));
      check($sformatf("und_fill_k%0d", k), 32'(fill_level), 32'(k >= 9 && k <= 12));
      if (k == 13) check("und_data", 32'(m_axis_data), 32'h1234);
      if (k == 8) begin
        s_axis_valid = 1'b1;
        s_axis_data  = 16'h1234;
      end
      if (k == 9) s_axis_valid = 1'b0;
    end
    enable = 1'b0;

    // ---- full FIFO: 17 offered, 16 accepted ----
    s_axis_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      s_axis_data = 16'h0100 + 16'(i);
      #1;
      check($sformatf("full_ready_%0d", i), 32'(s_axis_ready), 32'(i < 16));
      step();
    end
    check("full_fill16", 32'(fill_level), 16);
    s_axis_valid = 1'b0;
    rate_div     = 16'd1;
    m_axis_ready = 1'b1;
    enable       = 1'b1;
    #1;
    check("full_ready_on_pop", 32'(s_axis_ready), 0);
    for (int k = 1; k <= 32; k++) begin
      step();
      check($sformatf("full_valid_k%0d", k), 32'(m_axis_valid), 32'(k % 2));
      check($sformatf("full_late_k%0d", k), 32'(late), 32'((k % 2) == 0));
      if (k % 2 == 1)
        check($sformatf("full_data_k%0d", k), 32'(m_axis_data), 32'(16'h0100 + 16'((k - 1) / 2)));
    end
    enable = 1'b0;
    check("full_drained", 32'(fill_level), 0);

    // ---- late: rate_div=2, ready low for 6 cycles ----
    push_word(16'hA001);
    push_word(16'hA002);
    m_axis_ready = 1'b0;
    rate_div     = 16'd2;
    enable       = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("late_valid_k%0d", k), 32'(m_axis_valid), 32'(k <= 7 || k == 9));
      check($sformatf("late_pulse_k%0d", k), 32'(late), 32'(k == 3 || k == 5 || k == 7));
      check($sformatf("late_fill_k%0d", k), 32'(fill_level), 32'(k <= 8));
      check("late_underrun", 32'(underrun), 0);
      if (k <= 7) check($sformatf("late_hold_k%0d", k), 32'(m_axis_data), 32'hA001);
      if (k == 9) check("late_next", 32'(m_axis_data), 32'hA002);
      if (k == 7) m_axis_ready = 1'b1;
      if (k == 9) enable = 1'b0;
    end

    // ---- rate_div=0 behaves as 1; flush during PRESENT ----
    push_word(16'hD001);
    push_word(16'hD002);
    push_word(16'hD003);
    m_axis_ready = 1'b1;
    rate_div     = 16'd0;
    enable       = 1'b1;
    step();
    check("r0_k1_valid", 32'(m_axis_valid), 1);
    check("r0_k1_data",  32'(m_axis_data), 32'hD001);
    check("r0_k1_fill",  32'(fill_level), 2);
    step();
    check("r0_k2_valid", 32'(m_axis_valid), 0);
    check("r0_k2_late",  32'(late), 1);
    step();
    check("r0_k3_valid", 32'(m_axis_valid), 1);
    check("r0_k3_data",  32'(m_axis_data), 32'hD002);
    check("r0_k3_fill",  32'(fill_level), 1);
    flush        = 1'b1;
    m_axis_ready = 1'b0;
    step();
    check("flush_valid_held", 32'(m_axis_valid), 1);
    check("flush_data_held",  32'(m_axis_data), 32'hD002);
    check("flush_fill",       32'(fill_level), 0);
    check("flush_late",       32'(late), 1);
    flush        = 1'b0;
    m_axis_ready = 1'b1;
    step();
    check("flush_handshake", 32'(m_axis_valid), 0);
    check("flush_k5_late",   32'(late), 1);
    check("flush_k5_und",    32'(underrun), 0);
    step();
    check("flush_k6_und",    32'(underrun), 1);
    check("flush_k6_late",   32'(late), 0);
    check("flush_k6_valid",  32'(m_axis_valid), 0);
    enable = 1'b0;

    // ---- reset in the middle of PRESENT ----
    push_word(16'hE001);
    push_word(16'hE002);
    m_axis_ready = 1'b0;
    rate_div     = 16'd3;
    enable       = 1'b1;
    step();
    check("mid_valid", 32'(m_axis_valid), 1);
    check("mid_data",  32'(m_axis_data), 32'hE001);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(s_axis_ready), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("mid_rst_valid_%0d", k), 32'(m_axis_valid), 0);
      check($sformatf("mid_rst_data_%0d", k),  32'(m_axis_data), 0);
      check($sformatf("mid_rst_fill_%0d", k),  32'(fill_level), 0);
      check($sformatf("mid_rst_ready_%0d", k), 32'(s_axis_ready), 0);
    end
    rst    = 1'b0;
    enable = 1'b0;
    #1;
    check("mid_ready_after", 32'(s_axis_ready), 1);
    step();
    check("mid_valid_after", 32'(m_axis_valid), 0);
    check("mid_fill_after",  32'(fill_level), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dac_sample_pacer.md
# dac_sample_pacer

Rate-controlled sample source that sits directly upstream of the `dac_ad5541a` SPI driver. It buffers 16-bit samples arriving on an AXI-stream input in a small FIFO and releases exactly one sample per programmable sample period on its AXI-stream output. Its output feeds the driver's `s_axis_*` input. It reports underrun (no sample available at a period tick) and late (the previous sample is still unaccepted at a period tick).

## Interface
Parameters:
- `DATA_W`, 16: sample width.
- `DEPTH`, 16: FIFO depth; must be a power of 2, minimum 2.
- `DIV_W`, 16: width of `rate_div`.

Ports:
- `mclk`  in  1  single clock for the block.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  1 = pacing active; 0 = no new ticks.
- `flush`  in  1  synchronous FIFO clear; does not affect the word already presented on the output.
- `rate_div`  in  DIV_W  mclk cycles per sample period; 0 is treated as 1.
- `s_axis_valid`  in  1  upstream sample valid.
- `s_axis_ready`  out  1  FIFO can accept a word.
- `s_axis_data`  in  DATA_W  upstream sample.
- `m_axis_valid`  out  1  sample presented to the DAC driver.
- `m_axis_ready`  in  1  DAC driver accepts the sample.
- `m_axis_data`  out  DATA_W  presented sample.
- `fill_level`  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- `underrun`  out  1  one-cycle pulse: tick occurred with FIFO empty.
- `late`  out  1  one-cycle pulse: tick occurred while the output word was still pending.

## Operation
FIFO behaviour:
- Write occurs when `s_axis_valid && s_axis_ready`.
- `s_axis_ready = !full && !rst`, combinational from the registered count.
- When full, `s_axis_ready` is 0 even if a pop happens in the same cycle.
- Simultaneous write and pop: `fill_level` is unchanged.
- Pointers wrap modulo DEPTH.
- `flush` sets the count and pointers to 0. A write in the same cycle as `flush` is discarded.

Tick counter `tcnt`:
- When `enable` = 0: `tcnt` ← 0 and no tick is generated.
- When `enable` = 1 and `tcnt` == 0: `tick` is asserted and `tcnt` ← max(`rate_div`,1)−1.
- When `enable` = 1 and `tcnt` != 0: `tcnt` ← `tcnt`−1.
- The first tick occurs in the first cycle `enable` is high. The result is one tick every max(`rate_div`,1) cycles.
- A change to `rate_div` takes effect at the next reload.

Output FSM:
- States: `IDLE` and `PRESENT`.
- `IDLE` + tick + FIFO non-empty: pop the head into `m_axis_data` and go to `PRESENT`.
- `IDLE` + tick + FIFO empty: `underrun` ← 1 for one cycle; stay in `IDLE`.
- `PRESENT`: `m_axis_valid` = 1 and `m_axis_data` is held stable.
- `PRESENT` + `m_axis_ready`: go to `IDLE`. `m_axis_data` keeps its last value.
- `PRESENT` + tick (with or without `m_axis_ready`): `late` ← 1 for one cycle. That tick is dropped, with no pop.
- Dropping `enable` or asserting `flush` in `PRESENT` never withdraws `m_axis_valid`. The AXI rule holds: once valid, it is held until the handshake.

Reset (`rst`), effective at the next `mclk` edge:
- Registered state: FSM → `IDLE`, `tcnt` 0, FIFO count and pointers 0.
- Registered outputs: `m_axis_valid` 0, `m_axis_data` 0, `underrun` 0, `late` 0.
- Combinational: `fill_level` follows the count (0 after reset). `s_axis_ready` is 0 while `rst` is high.
- Reset mid-`PRESENT` discards the presented sample.

## Timing
- Tick to `m_axis_valid` = 1: 1 cycle (registered pop).
- FIFO write to `fill_level` update: 1 cycle.
- No fall-through: a word written in a tick cycle with the FIFO empty still causes an underrun. That word is popped at the next tick.
- The output handshake completes in the cycle `m_axis_valid && m_axis_ready`. The earliest next `m_axis_valid` is one tick later.
- `underrun` and `late` are registered and are never high in the same cycle.

## Structure
- Package `dac_stream_pkg`: `DATA_W` default constant and the FSM state enum `pacer_state_t` {`IDLE`, `PRESENT`}.
- Sub-module `sync_fifo`: parameters `DATA_W`, `DEPTH`; ports for push, pop, flush, full, empty and count. It is reusable by other stream stages.
- The tick counter and the FSM live in `dac_sample_pacer`.

## Test plan
- Reset: hold `rst` for 3 cycles mid-stream → `m_axis_valid`=0, `m_axis_data`=0, `fill_level`=0, `s_axis_ready`=0 during reset and 1 on the first cycle after.
- Pacing: `rate_div`=5. Preload 16'hCAFE, 16'hBEEF, 16'hFACE, 16'hC0DE; `m_axis_ready`=1; raise `enable`. Expect valid pulses exactly 5 cycles apart carrying the data in order, and `fill_level` 4→0.
- Underrun: FIFO empty, `rate_div`=4, `enable`=1 → `underrun` pulses every 4 cycles and `m_axis_valid` stays 0. A word written afterwards appears at the next tick.
- Full: `enable`=0, write 17 words → `s_axis_ready` drops after the 16th write, `fill_level`=16, and the 17th word is held upstream. Enable with `rate_div`=1 → all 16 words come out in order.
- Late: `rate_div`=2, `m_axis_ready` held low for 6 cycles after the first valid → `m_axis_valid` and `m_axis_data` stay stable, `late` pulses 3 times, and `fill_level` does not change.
- `rate_div`=0 with `m_axis_ready`=1 → behaves identically to 1: a tick every cycle and a sample on valid every 2 cycles. `flush` while in `PRESENT` → `fill_level`=0 while the presented word completes its handshake.
